// File: rtl/game_pkg.sv
// Shared definitions for the game round controller.
//   - game_state_e : top-level round state
//   - DEF_*        : default round/ready/end-hold lengths and the pause keycode
//   - round_*()    : split a frame count into M:SS BCD digits plus sub-second frames,
//                    used only on constants to build load values
package game_pkg;

   localparam int unsigned DEF_ROUND_FRAMES    = 10800;
   localparam int unsigned DEF_READY_FRAMES    = 180;
   localparam int unsigned DEF_END_HOLD_FRAMES = 120;
   localparam logic [7:0]  DEF_PAUSE_KEY       = 8'h13;

   localparam int unsigned FRAMES_PER_SEC = 60;
   localparam int unsigned TIMER_W        = 14;

   typedef enum logic [2:0] {
      StIdle,
      StReady,
      StPlay,
      StPaused,
      StEnd
   } game_state_e;

   function automatic logic [3:0] round_min_digit(input int unsigned frames);
      return 4'((frames / (60 * FRAMES_PER_SEC)) % 10);
   endfunction

   function automatic logic [3:0] round_tens_digit(input int unsigned frames);
      return 4'(((frames / FRAMES_PER_SEC) % 60) / 10);
   endfunction

   function automatic logic [3:0] round_ones_digit(input int unsigned frames);
      return 4'((frames / FRAMES_PER_SEC) % 10);
   endfunction

   function automatic logic [5:0] round_sub_frames(input int unsigned frames);
      return 6'(frames % FRAMES_PER_SEC);
   endfunction

endpackage

// File: rtl/round_bcd_counter.sv
// M:SS countdown in BCD with a sub-second frame counter underneath.
// The displayed time is always floor(remaining_frames / 60): the digits step
// down on the tick that takes the sub-second counter out of 0.
//   Clk, Reset  : clock, synchronous active-high reset (loads the LOAD_* values)
//   load        : reload LOAD_* values (wins over en)
//   en          : count one frame down; caller must not assert it at zero
//   min_ones, sec_tens, sec_ones : BCD digits
//   zero        : all digits and the sub-second counter are 0
module round_bcd_counter import game_pkg::*; #(
   parameter logic [3:0] LOAD_MIN  = 4'd3,
   parameter logic [3:0] LOAD_TENS = 4'd0,
   parameter logic [3:0] LOAD_ONES = 4'd0,
   parameter logic [5:0] LOAD_SUB  = 6'd0
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       load,
   input  logic       en,
   output logic [3:0] min_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       zero
);

   localparam logic [5:0] SubMax = 6'(FRAMES_PER_SEC - 1);

   logic [5:0] sub_q, sub_d;
   logic [3:0] min_q, min_d;
   logic [3:0] tens_q, tens_d;
   logic [3:0] ones_q, ones_d;

   assign zero = (sub_q == 6'd0) && (min_q == 4'd0) && (tens_q == 4'd0) && (ones_q == 4'd0);

   always_comb begin
      sub_d  = sub_q;
      min_d  = min_q;
      tens_d = tens_q;
      ones_d = ones_q;
      if (load) begin
         sub_d  = LOAD_SUB;
         min_d  = LOAD_MIN;
         tens_d = LOAD_TENS;
         ones_d = LOAD_ONES;
      end else if (en) begin
         if (sub_q != 6'd0) begin
            sub_d = sub_q - 6'd1;
         end else begin
            // Whole second consumed: borrow through ones -> tens -> minutes.
            sub_d = SubMax;
            if (ones_q != 4'd0) begin
               ones_d = ones_q - 4'd1;
            end else begin
               ones_d = 4'd9;
               if (tens_q != 4'd0) begin
                  tens_d = tens_q - 4'd1;
               end else begin
                  tens_d = 4'd5;
                  min_d  = min_q - 4'd1;
               end
            end
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sub_q  <= LOAD_SUB;
         min_q  <= LOAD_MIN;
         tens_q <= LOAD_TENS;
         ones_q <= LOAD_ONES;
      end else begin
         sub_q  <= sub_d;
         min_q  <= min_d;
         tens_q <= tens_d;
         ones_q <= ones_d;
      end
   end

   assign min_ones = min_q;
   assign sec_tens = tens_q;
   assign sec_ones = ones_q;

endmodule

// File: rtl/game_controller.sv
// Round sequencer for the game: idle -> 3-2-1 countdown -> timed play (pausable)
// -> end screen with a minimum hold, tracking the best final score.
//   Clk, Reset   : clock, synchronous active-high reset
//   vsync        : VGA vertical sync, one frame per rising edge (asynchronous)
//   keycode      : current USB keycode, 0 = none held
//   score        : live score from the gameplay logic
//   StartFlag    : READY, PLAY or PAUSED      EndFlag   : END
//   PauseFlag    : PAUSED                     ReadyFlag : READY
//   roundStart   : one-cycle pulse on READY -> PLAY
//   readyDigit   : 3/2/1 during READY, else 0
//   timerValue   : remaining round frames
//   minuteOnes, secondTens, secondOnes : remaining time as BCD M:SS
//   bestScore    : best final score since Reset
// Every output is a flop that changes on the edge where the causing tick/press is seen.
module game_controller import game_pkg::*; #(
   parameter int unsigned ROUND_FRAMES    = DEF_ROUND_FRAMES,
   parameter int unsigned READY_FRAMES    = DEF_READY_FRAMES,
   parameter int unsigned END_HOLD_FRAMES = DEF_END_HOLD_FRAMES,
   parameter logic [7:0]  PAUSE_KEY       = DEF_PAUSE_KEY
) (
   input  logic               Clk,
   input  logic               Reset,
   input  logic               vsync,
   input  logic [7:0]         keycode,
   input  logic [3:0]         score,
   output logic               StartFlag,
   output logic               EndFlag,
   output logic               PauseFlag,
   output logic               ReadyFlag,
   output logic               roundStart,
   output logic [1:0]         readyDigit,
   output logic [TIMER_W-1:0] timerValue,
   output logic [3:0]         minuteOnes,
   output logic [3:0]         secondTens,
   output logic [3:0]         secondOnes,
   output logic [3:0]         bestScore
);

   localparam int unsigned ReadyW = $clog2(READY_FRAMES + 2);
   localparam int unsigned HoldW  = $clog2(END_HOLD_FRAMES + 2);

   localparam logic [ReadyW-1:0]  ReadyLoad   = ReadyW'(READY_FRAMES);
   localparam logic [ReadyW-1:0]  ReadyOne    = ReadyW'(1);
   localparam logic [ReadyW-1:0]  ReadyOneSec = ReadyW'(FRAMES_PER_SEC);
   localparam logic [ReadyW-1:0]  ReadyTwoSec = ReadyW'(2 * FRAMES_PER_SEC);
   localparam logic [HoldW-1:0]   HoldLoad    = HoldW'(END_HOLD_FRAMES);
   localparam logic [HoldW-1:0]   HoldOne     = HoldW'(1);
   localparam logic [TIMER_W-1:0] TimerLoad   = TIMER_W'(ROUND_FRAMES);
   localparam logic [TIMER_W-1:0] TimerOne    = TIMER_W'(1);

   // Frame tick and key-press detection
   logic [2:0] vs_q;     // [0],[1] synchronizer, [2] edge history
   logic       tick;
   logic       key_q;
   logic       press;
   logic       pause_press;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         vs_q  <= 3'b000;
         key_q <= 1'b0;
      end else begin
         vs_q  <= {vs_q[1:0], vsync};
         key_q <= (keycode != 8'h00);
      end
   end

   assign tick        = vs_q[1] & ~vs_q[2];
   assign press       = (keycode != 8'h00) & ~key_q;
   assign pause_press = press & (keycode == PAUSE_KEY);

   // FSM: state register
   game_state_e state_q, state_d;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   logic [ReadyW-1:0]  ready_q, ready_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [HoldW-1:0]   hold_q, hold_d;
   logic [3:0]         best_d;

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:   if (press) state_d = StReady;
         StReady:  if (tick && ready_q == ReadyOne) state_d = StPlay;
         StPlay: begin
            // Expiry outranks a pause press landing on the same cycle.
            if (tick && timer_q == TimerOne) begin
               state_d = StEnd;
            end else if (pause_press) begin
               state_d = StPaused;
            end
         end
         StPaused: if (pause_press) state_d = StPlay;
         StEnd:    if (press && hold_q == '0) state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Counters and best score
   always_comb begin
      ready_d = ready_q;
      timer_d = timer_q;
      hold_d  = hold_q;
      best_d  = bestScore;
      if (state_q == StIdle && state_d == StReady) begin
         ready_d = ReadyLoad;
         timer_d = TimerLoad;
      end
      if (state_q == StReady && tick && ready_q != '0) begin
         ready_d = ready_q - ReadyOne;
      end
      if (state_q == StPlay && tick && timer_q != '0) begin
         timer_d = timer_q - TimerOne;
      end
      if (state_q == StPlay && state_d == StEnd) begin
         hold_d = HoldLoad;
         if (score > bestScore) begin
            best_d = score;
         end
      end
      if (state_q == StEnd && tick && hold_q != '0) begin
         hold_d = hold_q - HoldOne;
      end
      if (state_q == StEnd && state_d == StIdle) begin
         timer_d = TimerLoad;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         ready_q   <= '0;
         timer_q   <= TimerLoad;
         hold_q    <= '0;
         bestScore <= 4'd0;
      end else begin
         ready_q   <= ready_d;
         timer_q   <= timer_d;
         hold_q    <= hold_d;
         bestScore <= best_d;
      end
   end

   assign timerValue = timer_q;

   // BCD display countdown
   logic bcd_load;
   logic bcd_en;
   logic bcd_zero;

   assign bcd_load = (state_q == StIdle && state_d == StReady) ||
                     (state_q == StEnd && state_d == StIdle);
   assign bcd_en   = (state_q == StPlay) && tick && !bcd_zero;

   round_bcd_counter #(
      .LOAD_MIN  (round_min_digit(ROUND_FRAMES)),
      .LOAD_TENS (round_tens_digit(ROUND_FRAMES)),
      .LOAD_ONES (round_ones_digit(ROUND_FRAMES)),
      .LOAD_SUB  (round_sub_frames(ROUND_FRAMES))
   ) u_bcd (
      .Clk      (Clk),
      .Reset    (Reset),
      .load     (bcd_load),
      .en       (bcd_en),
      .min_ones (minuteOnes),
      .sec_tens (secondTens),
      .sec_ones (secondOnes),
      .zero     (bcd_zero)
   );

   // FSM: outputs, decoded from the next state so the flops line up with it
   logic       start_d;
   logic       end_d;
   logic       pause_d;
   logic       ready_flag_d;
   logic       round_start_d;
   logic [1:0] digit_d;

   always_comb begin
      start_d       = (state_d == StReady) || (state_d == StPlay) || (state_d == StPaused);
      end_d         = (state_d == StEnd);
      pause_d       = (state_d == StPaused);
      ready_flag_d  = (state_d == StReady);
      round_start_d = (state_q == StReady) && (state_d == StPlay);
      digit_d       = 2'd0;
      if (state_d == StReady) begin
         if (ready_d > ReadyTwoSec) begin
            digit_d = 2'd3;
         end else if (ready_d > ReadyOneSec) begin
            digit_d = 2'd2;
         end else begin
            digit_d = 2'd1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         StartFlag  <= 1'b0;
         EndFlag    <= 1'b0;
         PauseFlag  <= 1'b0;
         ReadyFlag  <= 1'b0;
         roundStart <= 1'b0;
         readyDigit <= 2'd0;
      end else begin
         StartFlag  <= start_d;
         EndFlag    <= end_d;
         PauseFlag  <= pause_d;
         ReadyFlag  <= ready_flag_d;
         roundStart <= round_start_d;
         readyDigit <= digit_d;
      end
   end

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with default parameters.
module tb_game_controller;

   logic        Clk;
   logic        Reset;
   logic        vsync;
   logic [7:0]  keycode;
   logic [3:0]  score;
   logic        StartFlag;
   logic        EndFlag;
   logic        PauseFlag;
   logic        ReadyFlag;
   logic        roundStart;
   logic [1:0]  readyDigit;
   logic [13:0] timerValue;
   logic [3:0]  minuteOnes;
   logic [3:0]  secondTens;
   logic [3:0]  secondOnes;
   logic [3:0]  bestScore;

   int n_tests = 0;
   int n_fail  = 0;
   int rs_cnt  = 0;

   game_controller dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .vsync      (vsync),
      .keycode    (keycode),
      .score      (score),
      .StartFlag  (StartFlag),
      .EndFlag    (EndFlag),
      .PauseFlag  (PauseFlag),
      .ReadyFlag  (ReadyFlag),
      .roundStart (roundStart),
      .readyDigit (readyDigit),
      .timerValue (timerValue),
      .minuteOnes (minuteOnes),
      .secondTens (secondTens),
      .secondOnes (secondOnes),
      .bestScore  (bestScore)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Count cycles roundStart is high, sampled mid-cycle.
   always @(negedge Clk) begin
      if (roundStart === 1'b1) rs_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_time(input string tag, input int t, input int m, input int st,
                             input int so);
      check({tag, " timer"}, 32'(timerValue), t);
      check({tag, " min"}, 32'(minuteOnes), m);
      check({tag, " tens"}, 32'(secondTens), st);
      check({tag, " ones"}, 32'(secondOnes), so);
   endtask

   // n frames, one vsync rising edge every 2 clocks, then let the pipeline settle.
   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge Clk); #1 vsync = 1'b1;
         @(posedge Clk); #1 vsync = 1'b0;
      end
      repeat (3) @(posedge Clk);
      #1;
   endtask

   task automatic press(input logic [7:0] k);
      @(posedge Clk); #1 keycode = k;
      @(posedge Clk); #1 keycode = 8'h00;
      @(posedge Clk); #1;
   endtask

   // One frame tick with a key press seen on the very same clock.
   task automatic tick_with_key(input logic [7:0] k);
      @(posedge Clk); #1 vsync = 1'b1;
      @(posedge Clk); #1 vsync = 1'b0;
      @(posedge Clk); #1 keycode = k;
      @(posedge Clk); #1 keycode = 8'h00;
      repeat (2) @(posedge Clk);
      #1;
   endtask

   initial begin
      Reset   = 1'b1;
      vsync   = 1'b0;
      keycode = 8'h00;
      score   = 4'd5;
      repeat (3) @(posedge Clk);
      #1 Reset = 1'b0;
      @(posedge Clk); #1;

      // Reset state
      check("rst start", 32'(StartFlag), 0);
      check("rst end", 32'(EndFlag), 0);
      check("rst pause", 32'(PauseFlag), 0);
      check("rst ready", 32'(ReadyFlag), 0);
      check("rst roundStart", 32'(roundStart), 0);
      check("rst digit", 32'(readyDigit), 0);
      check("rst best", 32'(bestScore), 0);
      check_time("rst", 10800, 3, 0, 0);

      // Round 1: countdown
      press(8'h04);
      check("r1 ready", 32'(ReadyFlag), 1);
      check("r1 start", 32'(StartFlag), 1);
      check("r1 digit3", 32'(readyDigit), 3);
      ticks(60);
      check("r1 digit2", 32'(readyDigit), 2);
      ticks(60);
      check("r1 digit1", 32'(readyDigit), 1);
      ticks(59);
      check("r1 ready@179", 32'(ReadyFlag), 1);
      rs_cnt = 0;
      ticks(1);
      check("r1 roundStart pulses", 32'(rs_cnt), 1);
      check("r1 ready off", 32'(ReadyFlag), 0);
      check("r1 digit0", 32'(readyDigit), 0);
      check("r1 play start", 32'(StartFlag), 1);
      check_time("r1 play", 10800, 3, 0, 0);

      // Play countdown, including a tens borrow
      ticks(60);
      check_time("r1 60t", 10740, 2, 5, 9);
      ticks(600);
      check_time("r1 660t", 10140, 2, 4, 9);

      // Pause / resume
      press(8'h13);
      check("pause flag", 32'(PauseFlag), 1);
      check("pause start", 32'(StartFlag), 1);
      ticks(100);
      check_time("paused 100t", 10140, 2, 4, 9);
      press(8'h05);
      check("pause other key", 32'(PauseFlag), 1);
      press(8'h13);
      check("resume flag", 32'(PauseFlag), 0);
      check("resume timer", 32'(timerValue), 10140);
      ticks(1);
      check_time("resume 1t", 10139, 2, 4, 8);

      // Expiry with a simultaneous pause press: END wins
      ticks(10138);
      check_time("r1 last frame", 1, 0, 0, 0);
      check("r1 not end yet", 32'(EndFlag), 0);
      tick_with_key(8'h13);
      check("r1 end", 32'(EndFlag), 1);
      check("r1 end no pause", 32'(PauseFlag), 0);
      check("r1 end start", 32'(StartFlag), 0);
      check_time("r1 end", 0, 0, 0, 0);
      check("r1 best", 32'(bestScore), 5);

      // End hold
      ticks(50);
      press(8'h04);
      check("hold 50 ignored", 32'(EndFlag), 1);
      ticks(69);
      press(8'h04);
      check("hold 119 ignored", 32'(EndFlag), 1);
      check("end timer held", 32'(timerValue), 0);
      ticks(1);
      @(posedge Clk); #1 keycode = 8'h04;
      @(posedge Clk); #1;
      check("hold done idle", 32'(EndFlag), 0);
      check("idle start", 32'(StartFlag), 0);
      check("idle ready", 32'(ReadyFlag), 0);
      repeat (5) @(posedge Clk);
      #1;
      check("held key single", 32'(ReadyFlag), 0);
      keycode = 8'h00;
      @(posedge Clk); #1;

      // Round 2: score 7 beats 5; READY ignores pause key
      score = 4'd7;
      press(8'h04);
      check("r2 ready", 32'(ReadyFlag), 1);
      press(8'h13);
      check("r2 ready ign pause", 32'(ReadyFlag), 1);
      check("r2 no pause", 32'(PauseFlag), 0);
      check("r2 digit", 32'(readyDigit), 3);
      rs_cnt = 0;
      ticks(180);
      check("r2 roundStart pulses", 32'(rs_cnt), 1);
      ticks(10799);
      check("r2 t10799 no end", 32'(EndFlag), 0);
      check("r2 t10799 timer", 32'(timerValue), 1);
      ticks(1);
      check("r2 end", 32'(EndFlag), 1);
      check_time("r2 end", 0, 0, 0, 0);
      check("r2 best", 32'(bestScore), 7);
      ticks(120);
      press(8'h04);
      check("r2 idle", 32'(EndFlag), 0);

      // Round 3: score 3 does not lower best
      score = 4'd3;
      press(8'h04);
      ticks(180);
      ticks(10800);
      check("r3 end", 32'(EndFlag), 1);
      check("r3 best kept", 32'(bestScore), 7);
      ticks(120);
      press(8'h04);
      check("r3 idle", 32'(EndFlag), 0);

      // Round 4: reset mid-play at 1:23
      press(8'h04);
      ticks(180);
      ticks(5820);
      check_time("r4 1:23", 4980, 1, 2, 3);
      @(posedge Clk); #1 Reset = 1'b1;
      repeat (2) @(posedge Clk);
      #1 Reset = 1'b0;
      @(posedge Clk); #1;
      check("r4 rst start", 32'(StartFlag), 0);
      check("r4 rst end", 32'(EndFlag), 0);
      check("r4 rst best", 32'(bestScore), 0);
      check_time("r4 rst", 10800, 3, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter ROUND_FRAMES, 10800, round length in frames (3:00 at 60 Hz).
REQ-002 SHALL have parameter READY_FRAMES, 180, pre-round countdown length in frames.
REQ-003 SHALL have parameter END_HOLD_FRAMES, 120, minimum end-screen time before a key is accepted.
REQ-004 SHALL have parameter PAUSE_KEY, 8'h13, HID keycode that toggles pause.
REQ-005 SHALL have one clock; reset is synchronous and active-high.
REQ-006 Ports:
  Clk  in  1  system clock
  Reset  in  1  synchronous, active-high
  vsync  in  1  VGA vertical sync, frame marker
  keycode  in  8  current USB keycode, 0 = none
  score  in  4  live score from gameplay logic
  StartFlag  out  1  high in READY, PLAY, PAUSED
  EndFlag  out  1  high in END
  PauseFlag  out  1  high in PAUSED
  ReadyFlag  out  1  high in READY
  roundStart  out  1  one-cycle pulse on READY->PLAY (clears score/orders)
  readyDigit  out  2  3/2/1 during READY, else 0
  timerValue  out  14  remaining round frames
  minuteOnes, secondTens, secondOnes  out  4 each  BCD of remaining time
  bestScore  out  4  highest final score since Reset

Function
REQ-007 SHALL pass vsync through a 2-flop synchronizer; frame tick = one-cycle pulse on rising edge of synchronized vsync.
REQ-008 SHALL define key press = keycode != 0 in this cycle and == 0 in the previous cycle; held keys produce one press.
REQ-009 SHALL implement states IDLE, READY, PLAY, PAUSED, END; all outputs registered, updating on the edge after the causing tick/press.
REQ-010 IDLE: any key press -> READY, load ready counter = READY_FRAMES, timer = ROUND_FRAMES, digits = 3:00.
REQ-011 READY: decrement ready counter per tick; readyDigit = 3 for counts 180..121, 2 for 120..61, 1 for 60..1; tick taking count 1->0 -> PLAY with roundStart pulsed that cycle.
REQ-012 PLAY: each tick decrements timerValue by 1 and BCD digits once per 60 ticks via a 0..59 sub-second counter; no dividers.
REQ-013 BCD borrow: secondOnes 0->9 borrows secondTens; secondTens 0->5 borrows minuteOnes; digits always equal floor(timerValue/60) as M:SS.
REQ-014 Tick taking timerValue 1->0 -> END; digits read 0:00; timerValue holds 0 in END.
REQ-015 PLAY: PAUSE_KEY press -> PAUSED; other keys ignored.
REQ-016 PAUSED: timer, digits, sub-second counter frozen; PAUSE_KEY press -> PLAY; other keys ignored.
REQ-017 Simultaneous expiring tick and PAUSE_KEY press in PLAY -> END wins.
REQ-018 On entry to END: bestScore <= score if score > bestScore; start END hold counter = END_HOLD_FRAMES.
REQ-019 END: key presses ignored until hold counter reaches 0; then any press -> IDLE; bestScore retained.
REQ-020 READY ignores all key presses, including PAUSE_KEY.

Reset
REQ-021 Reset SHALL force IDLE from any state, including mid-PLAY/PAUSED.
REQ-022 Reset values: all flags 0, roundStart 0, readyDigit 0, timerValue = ROUND_FRAMES, digits 3/0/0, bestScore 0, sub-second counter 0, synchronizer and key-history flops 0.

Structure
REQ-023 Package game_pkg SHALL hold the state enum, ROUND_FRAMES/READY_FRAMES/END_HOLD_FRAMES defaults and PAUSE_KEY.
REQ-024 BCD countdown (sub-second counter, three digits, load/enable/zero flag) SHALL be sub-module round_bcd_counter.

Verification
REQ-025 Reset, key 0x04 press in IDLE -> ReadyFlag next cycle, readyDigit 3; after 180 ticks -> PLAY, roundStart exactly one cycle, digits 3:00.
REQ-026 PLAY 60 ticks -> timerValue 10740, digits 2:59; 660 ticks from 3:00 -> 2:49 (tens borrow checked).
REQ-027 PLAY, press 0x13 -> PAUSED; 100 ticks -> timerValue unchanged; press 0x13 -> PLAY, decrement resumes next tick.
REQ-028 Run to expiry with score 7, bestScore 5 -> EndFlag after 10800th PLAY tick, 0:00, bestScore 7; next round score 3 -> bestScore stays 7.
REQ-029 In END press key at tick 50 -> ignored; press after 120 ticks -> IDLE; key held across transition -> no second press.
REQ-030 Reset asserted mid-PLAY at 1:23 -> IDLE, digits 3:00, bestScore 0.
